// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the multicycle CPU.
//   - instruction opcodes (instruction[31:26])
//   - FSM state encodings, including S_HALT
//   - ALUOp, PCSrc and RegDst codes
//   - ctrl_t: the bundle of datapath controls produced by control_decode
//   - opcode classification helpers used by both decode and next-state logic
package cpu_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // The eight working states use every 3-bit code, so HALT needs a fourth
    // bit. Only the low three bits are visible on the debug port.
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;

    // Next-PC select
    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // Destination register select
    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef struct packed {
        logic       PCWre;
        logic [1:0] PCSrc;
        logic       IRWre;
        logic       InsMemRW;
        logic       ExtSel;
        logic       ALUSrcA;
        logic       ALUSrcB;
        logic [2:0] ALUOp;
        logic       RegWre;
        logic [1:0] RegDst;
        logic       WrRegDSrc;
        logic       DataMemRW;
        logic       DBDataSrc;
    } ctrl_t;

    // Register-to-register and register-immediate ALU instructions
    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR,
            OP_AND, OP_ORI, OP_SLL, OP_SLT: is_alu_op = 1'b1;
            default:                        is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT: is_legal_op = 1'b1;
            default:                                            is_legal_op = is_alu_op(op);
        endcase
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB:         alu_op_of = ALU_SUB;
            OP_OR, OP_ORI:  alu_op_of = ALU_OR;
            OP_AND:         alu_op_of = ALU_AND;
            OP_SLL:         alu_op_of = ALU_SLL;
            OP_SLT:         alu_op_of = ALU_SLT;
            default:        alu_op_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational output decode for the multicycle
// controller.
//   st     in  state_t  current FSM state
//   opcode in  6        instruction opcode from the IR
//   zero   in  1        ALU zero flag (used only in EXE_BR)
//   ctrl   out ctrl_t   datapath enables and selects
module control_decode
    import cpu_pkg::*;
(
    input  state_t     st,
    input  logic [5:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl
);

    logic imm_op;

    assign imm_op = (opcode == OP_ADDI) || (opcode == OP_ORI);

    always_comb begin
        ctrl = '0;
        case (st)
            S_IF: begin
                ctrl.InsMemRW = 1'b1;
                ctrl.IRWre    = 1'b1;
            end

            // Jumps and illegal opcodes retire here; everything else waits.
            S_ID: begin
                if (opcode == OP_J) begin
                    ctrl.PCWre = 1'b1;
                    ctrl.PCSrc = PC_JUMP;
                end else if (opcode == OP_JR) begin
                    ctrl.PCWre = 1'b1;
                    ctrl.PCSrc = PC_RS;
                end else if (opcode == OP_JAL) begin
                    ctrl.PCWre     = 1'b1;
                    ctrl.PCSrc     = PC_JUMP;
                    ctrl.RegWre    = 1'b1;
                    ctrl.RegDst    = RD_RA;
                    ctrl.WrRegDSrc = 1'b0;
                end else if (!is_legal_op(opcode)) begin
                    ctrl.PCWre = 1'b1;
                    ctrl.PCSrc = PC_NEXT;
                end
            end

            // ALU controls stay valid through write-back so the result
            // feeding the register file does not change under it.
            S_EXE_AL, S_WB_AL: begin
                ctrl.ALUOp   = alu_op_of(opcode);
                ctrl.ALUSrcA = (opcode == OP_SLL);
                ctrl.ALUSrcB = imm_op;
                ctrl.ExtSel  = (opcode != OP_ORI);
                if (st == S_WB_AL) begin
                    ctrl.RegWre    = 1'b1;
                    ctrl.RegDst    = imm_op ? RD_RT : RD_RD;
                    ctrl.WrRegDSrc = 1'b1;
                    ctrl.DBDataSrc = 1'b0;
                    ctrl.PCWre     = 1'b1;
                    ctrl.PCSrc     = PC_NEXT;
                end
            end

            S_EXE_BR: begin
                ctrl.ALUOp  = ALU_SUB;
                ctrl.ExtSel = 1'b1;
                ctrl.PCWre  = 1'b1;
                ctrl.PCSrc  = zero ? PC_BRANCH : PC_NEXT;
            end

            // Address computation is held through MEM so the data memory
            // address stays stable during the access.
            S_EXE_LS, S_MEM: begin
                ctrl.ALUOp   = ALU_ADD;
                ctrl.ALUSrcB = 1'b1;
                ctrl.ExtSel  = 1'b1;
                if (st == S_MEM && opcode == OP_SW) begin
                    ctrl.DataMemRW = 1'b1;
                    ctrl.PCWre     = 1'b1;
                    ctrl.PCSrc     = PC_NEXT;
                end
            end

            S_WB_LD: begin
                ctrl.RegWre    = 1'b1;
                ctrl.RegDst    = RD_RT;
                ctrl.WrRegDSrc = 1'b1;
                ctrl.DBDataSrc = 1'b1;
                ctrl.PCWre     = 1'b1;
                ctrl.PCSrc     = PC_NEXT;
            end

            default: ctrl = '0;  // S_HALT: everything off, PC frozen
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing each instruction through
// IF / ID / EXE / MEM / WB and driving all datapath controls.
//   CLK       in   system clock, state advances on rising edge
//   RST       in   synchronous active-high reset
//   opcode    in   6  IR[31:26]
//   zero      in   ALU zero flag
//   PCWre, PCSrc[1:0], IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB,
//   ALUOp[2:0], RegWre, RegDst[1:0], WrRegDSrc, DataMemRW, DBDataSrc
//             out  datapath controls
//   state     out  3  current state (debug); HALT reads as 000 with all
//                     controls low, which distinguishes it from IF
module multicycle_control
    import cpu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DataMemRW,
    output logic       DBDataSrc,
    output logic [2:0] state
);

    state_t st;
    ctrl_t  dec;
    ctrl_t  ctrl;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st <= S_IF;
        end else begin
            case (st)
                S_IF:     st <= S_ID;
                S_ID: begin
                    if (opcode == OP_HALT)                        st <= S_HALT;
                    else if (opcode == OP_BEQ)                    st <= S_EXE_BR;
                    else if (opcode == OP_SW || opcode == OP_LW)  st <= S_EXE_LS;
                    else if (is_alu_op(opcode))                   st <= S_EXE_AL;
                    else                                          st <= S_IF;
                end
                S_EXE_AL: st <= S_WB_AL;
                S_WB_AL:  st <= S_IF;
                S_EXE_BR: st <= S_IF;
                S_EXE_LS: st <= S_MEM;
                S_MEM:    st <= (opcode == OP_LW) ? S_WB_LD : S_IF;
                S_WB_LD:  st <= S_IF;
                S_HALT:   st <= S_HALT;
                default:  st <= S_IF;
            endcase
        end
    end

    control_decode u_decode (
        .st     (st),
        .opcode (opcode),
        .zero   (zero),
        .ctrl   (dec)
    );

    // During reset the PC must be written (its own reset lands on the
    // falling edge) while every other control is held off, which also
    // kills any write-back of an aborted instruction.
    always_comb begin
        ctrl = dec;
        if (RST) begin
            ctrl       = '0;
            ctrl.PCWre = 1'b1;
            ctrl.PCSrc = PC_NEXT;
        end
    end

    assign PCWre     = ctrl.PCWre;
    assign PCSrc     = ctrl.PCSrc;
    assign IRWre     = ctrl.IRWre;
    assign InsMemRW  = ctrl.InsMemRW;
    assign ExtSel    = ctrl.ExtSel;
    assign ALUSrcA   = ctrl.ALUSrcA;
    assign ALUSrcB   = ctrl.ALUSrcB;
    assign ALUOp     = ctrl.ALUOp;
    assign RegWre    = ctrl.RegWre;
    assign RegDst    = ctrl.RegDst;
    assign WrRegDSrc = ctrl.WrRegDSrc;
    assign DataMemRW = ctrl.DataMemRW;
    assign DBDataSrc = ctrl.DBDataSrc;

    assign state = (RST || st == S_HALT) ? 3'b000 : st[2:0];

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: a driver issues instructions and pushes
// the expected per-cycle control vectors into a scoreboard queue; a monitor
// pops and compares one vector on every falling edge.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
    logic       RegWre, WrRegDSrc, DataMemRW, DBDataSrc;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    multicycle_control dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DataMemRW(DataMemRW), .DBDataSrc(DBDataSrc), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre;
        logic [1:0] pcsrc;
        logic       irwre, imem, ext, srca, srcb;
        logic [2:0] aluop;
        logic       regwre;
        logic [1:0] regdst;
        logic       wrsrc, dmrw, dbsrc;
    } exp_t;

    typedef struct {
        exp_t  v;
        string tag;
    } item_t;

    item_t sb[$];
    exp_t  act;
    item_t mon_it;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    finish_req = 1'b0;

    assign act = {state, PCWre, PCSrc, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB,
                  ALUOp, RegWre, RegDst, WrRegDSrc, DataMemRW, DBDataSrc};

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: one expected vector per cycle while the scoreboard has work.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_it = sb.pop_front();
            total = total + 1;
            if (act !== mon_it.v) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d got=%05h want=%05h", mon_it.tag, cyc, act, mon_it.v);
            end
        end else if (finish_req) begin
            total = total + 1;
            if (sb.size() != 0) begin
                bad = bad + 1;
                $display("FAIL drain got=%0d want=0", sb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Per-instruction cycle sequences written straight from the instruction
    // classes: each class has a fixed list of phases and control settings.

    function automatic void push(input exp_t e, input string tag);
        item_t it;
        it.v = e;
        it.tag = tag;
        sb.push_back(it);
    endfunction

    function automatic exp_t reset_vec();
        exp_t e = '0;
        e.pcwre = 1'b1;
        return e;
    endfunction

    // ALU instruction table: returns 1 if op is an ALU-class instruction.
    function automatic bit alu_info(input logic [5:0] op, output logic [2:0] aop,
                                    output logic a, output logic b, output logic ext,
                                    output logic [1:0] rd);
        a = 0; b = 0; ext = 1; rd = 2'b10; aop = 3'b000;
        case (op)
            6'b000000: aop = 3'b000;
            6'b000001: aop = 3'b001;
            6'b000010: begin aop = 3'b000; b = 1; rd = 2'b01; end
            6'b010000: aop = 3'b100;
            6'b010001: aop = 3'b101;
            6'b010010: begin aop = 3'b100; b = 1; ext = 0; rd = 2'b01; end
            6'b011000: begin aop = 3'b011; a = 1; end
            6'b100110: aop = 3'b010;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        logic [2:0] x; logic y0, y1, y2; logic [1:0] r;
        case (op)
            6'b110000, 6'b110001, 6'b110100, 6'b111000,
            6'b111001, 6'b111010, 6'b111111: return 1'b1;
            default: return alu_info(op, x, y0, y1, y2, r);
        endcase
    endfunction

    // Called right after a rising edge with the DUT in IF. Pushes all
    // expected cycles and waits until the next IF.
    task automatic run_instr(input logic [5:0] op, input logic z, input int halt_cycles);
        exp_t e;
        int n;
        logic [2:0] aop; logic a, b, ext; logic [1:0] rd;
        opcode = op;
        zero = z;
        e = '0; e.imem = 1; e.irwre = 1;
        push(e, "IF"); n = 1;
        e = '0; e.st = 3'b001;
        if (op == 6'b111000) begin
            e.pcwre = 1; e.pcsrc = 2'b11; push(e, "ID_j"); n++;
        end else if (op == 6'b111001) begin
            e.pcwre = 1; e.pcsrc = 2'b10; push(e, "ID_jr"); n++;
        end else if (op == 6'b111010) begin
            e.pcwre = 1; e.pcsrc = 2'b11; e.regwre = 1; e.regdst = 2'b00; e.wrsrc = 0;
            push(e, "ID_jal"); n++;
        end else if (!is_legal(op)) begin
            e.pcwre = 1; push(e, "ID_illegal"); n++;
        end else if (op == 6'b111111) begin
            push(e, "ID_halt"); n++;
            e = '0;  // halted: every output low, debug state reads 000
            for (int i = 0; i < halt_cycles; i++) begin push(e, "HALT"); n++; end
        end else if (op == 6'b110100) begin
            push(e, "ID_beq"); n++;
            e = '0; e.st = 3'b101; e.aluop = 3'b001; e.ext = 1; e.pcwre = 1;
            e.pcsrc = z ? 2'b01 : 2'b00;
            push(e, "EXE_BR"); n++;
        end else if (op == 6'b110000 || op == 6'b110001) begin
            push(e, "ID_ls"); n++;
            e = '0; e.st = 3'b010; e.aluop = 3'b000; e.srcb = 1; e.ext = 1;
            push(e, "EXE_LS"); n++;
            e.st = 3'b011;
            if (op == 6'b110000) begin
                e.dmrw = 1; e.pcwre = 1; push(e, "MEM_sw"); n++;
            end else begin
                push(e, "MEM_lw"); n++;
                e = '0; e.st = 3'b100; e.regwre = 1; e.regdst = 2'b01; e.wrsrc = 1;
                e.dbsrc = 1; e.pcwre = 1;
                push(e, "WB_LD"); n++;
            end
        end else begin
            void'(alu_info(op, aop, a, b, ext, rd));
            push(e, "ID_al"); n++;
            e = '0; e.st = 3'b110; e.aluop = aop; e.srca = a; e.srcb = b; e.ext = ext;
            push(e, "EXE_AL"); n++;
            e.st = 3'b111; e.regwre = 1; e.regdst = rd; e.wrsrc = 1; e.pcwre = 1;
            push(e, "WB_AL"); n++;
        end
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            RST = 1'b1;
            push(reset_vec(), "RST");
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        return op;
    endfunction

    logic [5:0] ops [14] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                             6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                             6'b110100, 6'b111000, 6'b111001, 6'b111010};

    // ---------------- driver ----------------
    initial begin
        @(posedge CLK);
        #1;
        do_reset(2);
        run_instr(6'b000000, 1'b0, 0);   // add
        run_instr(6'b000010, 1'b1, 0);   // addi
        run_instr(6'b110100, 1'b1, 0);   // beq taken
        run_instr(6'b110100, 1'b0, 0);   // beq not taken
        run_instr(6'b110000, 1'b1, 0);   // sw
        run_instr(6'b110001, 1'b0, 0);   // lw
        run_instr(6'b111010, 1'b0, 0);   // jal
        run_instr(6'b111001, 1'b1, 0);   // jr
        run_instr(6'b101010, 1'b0, 0);   // illegal
        run_instr(6'b011000, 1'b0, 0);   // sll
        run_instr(6'b010010, 1'b0, 0);   // ori

        // add aborted by reset in EXE_AL: no write-back, next cycle is IF
        opcode = 6'b000000;
        begin
            exp_t e;
            e = '0; e.imem = 1; e.irwre = 1; push(e, "IF_abort");
            e = '0; e.st = 3'b001; push(e, "ID_abort");
        end
        repeat (2) @(posedge CLK);
        #1;
        do_reset(1);
        run_instr(6'b000001, 1'b0, 0);   // sub

        run_instr(6'b111111, 1'b0, 10);  // halt, held 10 cycles
        do_reset(2);

        for (int i = 0; i < 200; i++) begin
            int k;
            logic [5:0] op;
            k = $urandom_range(0, 15);
            op = (k >= 14) ? rand_illegal() : ops[k];
            run_instr(op, 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 19) == 0) do_reset(1 + $urandom_range(0, 1));
        end

        finish_req = 1'b1;
    end

endmodule
